// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract step: brings in the dividend MSB, trial-subtracts the divisor.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_dvd,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted  = {rem, dvd[WIDTH-1]};
    // Extra guard bit so the borrow is visible even when shifted has its MSB set.
    diff     = {1'b0, shifted} - {2'b00, divisor};
    q_bit    = ~diff[WIDTH+1];
    next_rem = q_bit ? WIDTH'(diff) : WIDTH'(shifted);
    next_dvd = {dvd[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  seq_divider_if.slave    bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remd_q;
  logic             dbz_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dvd;
  logic             step_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd      (dvd_q),
    .divisor  (dsr_q),
    .next_rem (step_rem),
    .next_dvd (step_dvd),
    .q_bit    (step_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
      quot_q <= '0;
      remd_q <= '0;
      dbz_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            dvd_q <= bus.dividend;
            dsr_q <= bus.divisor;
            rem_q <= '0;
            count <= '0;
            if (bus.divisor == '0) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              quot_q <= '1;
              remd_q <= bus.dividend;
              dbz_q  <= 1'b1;
            end else begin
              state  <= RUN;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        RUN: begin
          // The quotient accumulates in the dividend register as its bits shift out.
          rem_q <= step_rem;
          dvd_q <= step_dvd;
          count <= count + 1'b1;
          if (count == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            quot_q <= step_dvd;
            remd_q <= step_rem;
            dbz_q  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remd_q;
  assign bus.div_by_zero = dbz_q;

  // step_qbit is already folded into step_dvd; referenced here only to keep it observable.
  logic unused_qbit;
  assign unused_qbit = step_qbit;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 32: operand, quotient and remainder width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE or DONE.
REQ-005 dividend  input  WIDTH  unsigned dividend; captured on the accepted start edge.
REQ-006 divisor  input  WIDTH  unsigned divisor; captured on the accepted start edge.
REQ-007 busy  output  1  high while in RUN.
REQ-008 done  output  1  one-cycle pulse; quotient, remainder and div_by_zero are valid while it is high.
REQ-009 quotient  output  WIDTH  unsigned quotient.
REQ-010 remainder  output  WIDTH  unsigned remainder.
REQ-011 div_by_zero  output  1  set with done when the captured divisor was zero.

Function
REQ-012 States: IDLE, RUN, DONE; encoding is 2 bits.
REQ-013 IDLE or DONE with start=1: capture operands, clear the partial remainder, clear iteration count, go to RUN; divisor zero goes to DONE directly.
REQ-014 IDLE with start=0 stays in IDLE; DONE with start=0 goes to IDLE.
REQ-015 RUN performs one restoring step per edge, MSB first: shift {rem, dvd} left 1; trial = rem - divisor over WIDTH+1 bits; no borrow -> rem=trial, quotient bit=1; else quotient bit=0.
REQ-016 RUN lasts exactly WIDTH edges; on the WIDTH-th step edge, go to DONE.
REQ-017 Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH (k+1 for divide-by-zero).
REQ-018 done is high only in DONE; busy is high only in RUN.
REQ-019 Divide-by-zero: quotient = all ones, remainder = dividend, div_by_zero=1 for the done cycle.
REQ-020 start in RUN is ignored; operand changes after capture have no effect.
REQ-021 start in DONE is accepted (back-to-back); outputs for the finished op remain valid during that DONE cycle.
REQ-022 quotient/remainder/div_by_zero hold their last values in IDLE until the next op completes.
REQ-023 Invariant at done (divisor != 0): dividend == quotient*divisor + remainder, remainder < divisor.

Reset
REQ-024 rst=1 at an edge forces IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, count=0.
REQ-025 rst has priority over start and aborts an op in RUN or DONE; no done pulse follows.

Structure
REQ-026 A shared package holds the state typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-027 One combinational sub-module, div_step, computes one shift-subtract step (inputs rem, dvd, divisor; outputs next rem, next dvd, quotient bit).
REQ-028 The top module holds the FSM, iteration counter ($clog2(WIDTH)+1 bits) and registers.

Verification
REQ-029 100 / 7 -> done after 32 cycles: quotient=14, remainder=2, div_by_zero=0.
REQ-030 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0; 5 / 9 -> quotient=0, remainder=5.
REQ-031 1234 / 0 -> done at next cycle: quotient=0xFFFFFFFF, remainder=1234, div_by_zero=1.
REQ-032 Start 100/7, pulse start with 50/5 at cycle 10 -> second ignored; result 14 r 2; busy high for exactly 32 cycles.
REQ-033 rst asserted at cycle 15 of RUN -> next cycle IDLE, all outputs 0, no done pulse; new 9/3 then gives 3 r 0.
REQ-034 Back-to-back: start held high -> 100/7 then 81/9 complete with done 33 cycles apart; 1000 random pairs satisfy REQ-023.
